// File: rtl/clb_pkg.sv
// clb_pkg: shared sizing constants for the CLB tile.
// Config word is the select bit at bit 0, with the truth table above it.
package clb_pkg;

    localparam int CLB_K       = 4;
    localparam int LUT_BITS    = 2 ** CLB_K;
    localparam int CFG_BITS    = LUT_BITS + 1;
    localparam int CFG_SEL_BIT = 0;
    localparam int CFG_LUT_LSB = 1;

endpackage

// File: rtl/clb_if.sv
// clb_if: programming chain and fabric-side logic signals of one tile.
// The host/fabric side uses master; the tile uses slave.
interface clb_if
    import clb_pkg::*;
#(
    parameter int K = CLB_K
);

    logic         prog_en;
    logic         prog_in;
    logic [K-1:0] clb_input;
    logic         prog_out;
    logic         clb_output;

    modport master (
        output prog_en,
        output prog_in,
        output clb_input,
        input  prog_out,
        input  clb_output
    );

    modport slave (
        input  prog_en,
        input  prog_in,
        input  clb_input,
        output prog_out,
        output clb_output
    );

endinterface

// File: rtl/clb_lut.sv
// clb_lut: 2**K-to-1 truth-table selector.
// Every select value addresses a real entry, so no default case exists.
module clb_lut #(
    parameter int K = 4
) (
    input  logic [2**K-1:0] lut_tbl,
    input  logic [K-1:0]    sel,
    output logic            lut_out
);

    assign lut_out = lut_tbl[sel];

endmodule

// File: rtl/clb_cell.sv
// clb_cell: one CLB tile with a serial config chain,
// a K-input LUT and an optional output flip-flop.
module clb_cell
    import clb_pkg::*;
#(
    parameter int K = CLB_K
) (
    input  logic clb_clk,
    input  logic clb_rst_n,
    clb_if.slave bus
);

    localparam int NLUT = 2 ** K;
    localparam int NCFG = NLUT + 1;

    logic [NCFG-1:0] cfg_q;
    logic            ff_q;
    logic            lut_out;
    logic            mux_out;

    // Config shifts MSB toward bit 0, so the select bit goes in first.
    always_ff @(posedge clb_clk) begin
        if (!clb_rst_n) begin
            cfg_q <= '0;
        end else if (bus.prog_en) begin
            cfg_q <= {bus.prog_in, cfg_q[NCFG-1:1]};
        end
    end

    // Frozen during programming so partial tables are never captured.
    always_ff @(posedge clb_clk) begin
        if (!clb_rst_n) begin
            ff_q <= 1'b0;
        end else if (!bus.prog_en) begin
            ff_q <= lut_out;
        end
    end

    clb_lut #(
        .K(K)
    ) u_lut (
        .lut_tbl(cfg_q[NCFG-1:CFG_LUT_LSB]),
        .sel    (bus.clb_input),
        .lut_out(lut_out)
    );

    assign mux_out = cfg_q[CFG_SEL_BIT] ? ff_q : lut_out;

    assign bus.prog_out   = cfg_q[0];
    assign bus.clb_output = bus.prog_en ? 1'b0 : mux_out;

endmodule

// File: tb/tb_clb_cell.sv
// tb_clb_cell: directed vectors for the CLB tile.
// Inputs change 1ns after each rising edge; outputs are sampled before the next.
module tb_clb_cell;

    logic clb_clk;
    logic clb_rst_n;
    int   n_cmp;
    int   n_bad;

    clb_if #(.K(4)) bus ();

    clb_cell #(
        .K(4)
    ) dut (
        .clb_clk  (clb_clk),
        .clb_rst_n(clb_rst_n),
        .bus      (bus)
    );

    initial clb_clk = 1'b0;
    always #5 clb_clk = ~clb_clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clb_clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [15:0] tbl);
        bus.prog_en = 1'b1;
        bus.prog_in = sel;
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.prog_in = tbl[i];
            tick();
        end
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        #1;
    endtask

    initial begin
        logic [3:0] v;
        logic       par;
        n_cmp         = 0;
        n_bad         = 0;
        clb_rst_n     = 1'b0;
        bus.prog_en   = 1'b1;
        bus.prog_in   = 1'b1;
        bus.clb_input = 4'h0;

        // reset wins over an active shift
        repeat (3) tick();
        check("rst_prog_out", {31'd0, bus.prog_out}, 32'd0);
        check("rst_cfg", {15'd0, dut.cfg_q}, 32'd0);
        bus.prog_en = 1'b0;
        #1;
        check("rst_out", {31'd0, bus.clb_output}, 32'd0);
        clb_rst_n = 1'b1;
        tick();

        // AND4, combinational
        load(1'b0, 16'h8000);
        check("and_cfg", {15'd0, dut.cfg_q}, 32'h10000);
        bus.clb_input = 4'hF;
        #1;
        check("and_F", {31'd0, bus.clb_output}, 32'd1);
        bus.clb_input = 4'hE;
        #1;
        check("and_E", {31'd0, bus.clb_output}, 32'd0);
        bus.clb_input = 4'h0;
        #1;
        check("and_0", {31'd0, bus.clb_output}, 32'd0);

        // masking during configuration
        bus.clb_input = 4'hF;
        tick();
        check("mask_pre", {31'd0, bus.clb_output}, 32'd1);
        check("mask_ff1", {31'd0, dut.ff_q}, 32'd1);
        bus.prog_en = 1'b1;
        #1;
        check("mask_out", {31'd0, bus.clb_output}, 32'd0);
        bus.clb_input = 4'h0;
        tick();
        check("mask_hold", {31'd0, dut.ff_q}, 32'd1);
        check("mask_out2", {31'd0, bus.clb_output}, 32'd0);
        bus.prog_en = 1'b0;
        #1;

        // XOR4 parity, registered
        load(1'b1, 16'h6996);
        check("xor_sel", {31'd0, bus.prog_out}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            bus.clb_input = v;
            #1;
            if (i > 0) begin
                par = ^(v - 4'd1);
                check($sformatf("xor_lat%0d", i),
                      {31'd0, bus.clb_output}, {31'd0, par});
            end
            tick();
            par = ^v;
            check($sformatf("xor_reg%0d", i),
                  {31'd0, bus.clb_output}, {31'd0, par});
        end
        bus.clb_input = 4'h7;
        tick();
        bus.clb_input = 4'h0;
        #1;
        check("xor_7_then_0", {31'd0, bus.clb_output}, 32'd1);
        tick();
        check("xor_0_reg", {31'd0, bus.clb_output}, 32'd0);

        // chain pass-through
        clb_rst_n = 1'b0;
        tick();
        clb_rst_n   = 1'b1;
        bus.prog_en = 1'b1;
        bus.prog_in = 1'b1;
        tick();
        bus.prog_in = 1'b0;
        for (int i = 2; i <= 17; i++) begin
            tick();
            if (i == 16)
                check("chain_e16", {31'd0, bus.prog_out}, 32'd0);
        end
        check("chain_e17", {31'd0, bus.prog_out}, 32'd1);
        tick();
        check("chain_e18", {31'd0, bus.prog_out}, 32'd0);

        // reset in the middle of a load
        bus.prog_in = 1'b1;
        repeat (9) tick();
        check("mid_partial", {15'd0, dut.cfg_q}, 32'h1FF00);
        clb_rst_n = 1'b0;
        tick();
        clb_rst_n   = 1'b1;
        bus.prog_en = 1'b0;
        bus.prog_in = 1'b0;
        #1;
        check("mid_cfg", {15'd0, dut.cfg_q}, 32'd0);
        check("mid_prog_out", {31'd0, bus.prog_out}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            bus.clb_input = i[3:0];
            #1;
            check($sformatf("mid_out%0d", i),
                  {31'd0, bus.clb_output}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clb_cell.md
Name: clb_cell

Overview:
- Single configurable logic block (CLB) tile for the soft-FPGA fabric.
- Holds a serially loaded configuration word. The word has two fields:
  - a K-input lookup-table truth table;
  - one output-select bit choosing combinational (LUT) or registered (flip-flop) output.
- Configuration chains tile-to-tile through prog_in/prog_out.
- Logic inputs come from the routing fabric, and clb_output drives back into it.

Parameters:
- K, default 4: number of LUT select inputs.
- LUT_BITS, default 2**K (16): truth-table size. Derived; not overridden.
- CFG_BITS, default LUT_BITS+1 (17): configuration register length. Derived.

Ports:
- clb_clk, input, 1: the single clock. Shifting and the flip-flop both use its rising edge.
- clb_rst_n, input, 1: synchronous, active-low reset.
- prog_en, input, 1: configuration mode enable.
- prog_in, input, 1: serial configuration data in.
- clb_input, input, K: LUT select inputs.
- prog_out, output, 1: serial configuration data out, to the next tile.
- clb_output, output, 1: logic output.

Behaviour:
- Interface: one clock (clb_clk); reset is synchronous and active-low (clb_rst_n).
- Config register cfg[CFG_BITS-1:0]:
  - cfg[0] is the output-select bit.
  - cfg[CFG_BITS-1:1] is the truth table. Table entry i is cfg[i+1].
- Reset: on a rising clb_clk edge with clb_rst_n=0:
  - cfg <= 0 and ff <= 0;
  - consequently prog_out=0 and clb_output=0.
  - Reset has priority over prog_en.
- Shift: on an edge with clb_rst_n=1 and prog_en=1, cfg <= {prog_in, cfg[CFG_BITS-1:1]}.
  - Data moves from the MSB toward bit 0.
  - With prog_en=0, cfg holds.
- prog_out = cfg[0], combinational from the register.
  - The first bit shifted in reaches prog_out after CFG_BITS edges.
  - It leaves the tile on edge CFG_BITS+1.
- Load order for a full load: output-select bit first, then table entries 0, 1, ..., LUT_BITS-1, with entry LUT_BITS-1 shifted in last.
- LUT: lut_out = cfg[clb_input+1]. Purely combinational, zero latency. Every clb_input value 0..LUT_BITS-1 is valid; there is no out-of-range case.
- Flip-flop: on an edge with clb_rst_n=1 and prog_en=0, ff <= lut_out.
  - It holds while prog_en=1, so partially shifted tables are never captured.
- Output mux: mux_out = cfg[0] ? ff : lut_out.
- clb_output = prog_en ? 0 : mux_out. It is forced low throughout configuration.
- Timing:
  - combinational mode: clb_input-to-output latency is 0 cycles;
  - registered mode: latency is 1 cycle.
- Deassertion of prog_en:
  - Output is valid in the same cycle.
  - In registered mode, ff still holds its pre-configuration value until the next edge.
- Reset asserted mid-load: cfg clears and the partial load is discarded. The host must restart the full CFG_BITS-bit load.

Decomposition:
- Package clb_pkg: parameter K default and derived constants LUT_BITS and CFG_BITS.
  - Localparam CFG_SEL_BIT = 0.
  - Localparam CFG_LUT_LSB = 1.
- One natural sub-module, clb_lut: a parameterised LUT_BITS-to-1 selector, with table and select in, lut_out out.
- The flip-flop, output mux, and shift register stay inline in clb_cell.

Test Plan:
- Reset: drive prog_in=1 and prog_en=1 with clb_rst_n=0 for 3 edges. Required: prog_out=0 and clb_output=0.
- AND4, combinational:
  - Shift select bit 0, then entries 0..14 as 0 and entry 15 as 1 (17 edges, table 16'h8000), then prog_en=0.
  - clb_input=4'hF gives clb_output=1 in the same cycle.
  - clb_input=4'hE and 4'h0 give clb_output=0.
- XOR4 parity, registered:
  - Load select bit 1 and table 16'h6996.
  - Sweep clb_input 0..15 on consecutive edges.
  - clb_output equals the parity of the previous cycle's clb_input (e.g. input 4'h7 followed by 4'h0 gives output 1 one edge later).
- Masking: with AND4 loaded and clb_input=4'hF, raise prog_en=1. clb_output drops to 0 immediately; ff does not change while prog_en=1.
- Chain pass-through: after reset, shift 17 bits whose first bit is 1 and rest 0.
  - prog_out rises after edge 17.
  - With prog_in=0 and one more edge, prog_out=0.
- Reset mid-load: shift 9 bits of 1, pulse clb_rst_n=0 for one edge, then prog_en=0.
  - cfg is all zero and clb_output=0 for every clb_input.
